// File: rtl/controle_linha_vedacao_pkg.sv
`default_nettype none
// ============================================================================
// controle_linha_vedacao_pkg
// State codes and default timings shared by the bottling/corking station.
// Revision: 1.0
// ============================================================================
package controle_linha_vedacao_pkg;

    typedef enum logic [3:0] {
        PARADO        = 4'd0,
        TRANSPORTE    = 4'd1,
        ENCHIMENTO    = 4'd2,
        AGUARDA_ROLHA = 4'd3,
        VEDACAO       = 4'd4,
        LIBERA        = 4'd5,
        CONTA         = 4'd6,
        LOTE_COMPLETO = 4'd7,
        ERRO          = 4'd8
    } estado_t;

    localparam int c_TEMPO_VEDACAO_PADRAO      = 20;
    localparam int c_TIMEOUT_ENCHIMENTO_PADRAO = 200;
    localparam int c_TEMPO_CONTA_PADRAO        = 2;

    function automatic int maximo3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/controle_linha_vedacao_temporizador_estado.sv
`default_nettype none
// ============================================================================
// temporizador_estado
// Saturating up-counter with synchronous clear and terminal-count compare.
// Revision: 1.0
// ============================================================================
module temporizador_estado #(
    parameter int LARGURA = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_limpa,
    input  logic               i_habilita,
    input  logic [LARGURA-1:0] i_limite,
    output logic [LARGURA-1:0] o_contagem,
    output logic               o_fim
);

    logic [LARGURA-1:0] r_contagem;

    always_ff @(posedge clk) begin
        if (rst || i_limpa) begin
            r_contagem <= '0;
        end else if (i_habilita && (r_contagem != {LARGURA{1'b1}})) begin
            r_contagem <= r_contagem + 1'b1;
        end
    end

    assign o_contagem = r_contagem;
    assign o_fim      = (r_contagem == i_limite);

endmodule
`default_nettype wire

// File: rtl/controle_linha_vedacao.sv
`default_nettype none
// ============================================================================
// controle_linha_vedacao
// Per-bottle sequencer for conveyor, fill valve and corking press (Moore FSM).
// Revision: 1.0
// ============================================================================
module controle_linha_vedacao
    import controle_linha_vedacao_pkg::*;
#(
    parameter int TEMPO_VEDACAO      = c_TEMPO_VEDACAO_PADRAO,
    parameter int TIMEOUT_ENCHIMENTO = c_TIMEOUT_ENCHIMENTO_PADRAO,
    parameter int TEMPO_CONTA        = c_TEMPO_CONTA_PADRAO
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       LIGA,
    input  logic       SENSOR_POSICAO,
    input  logic       SENSOR_NIVEL,
    input  logic       ROLHA_DISPONIVEL,
    input  logic       ALARME_SEM_ROLHA,
    input  logic       LIMITE_DUZIAS,
    output logic       MOTOR_ESTEIRA,
    output logic       VALVULA_ENCHIMENTO,
    output logic       ATUADOR_VEDACAO,
    output logic       DECREMENTA_ROLHA,
    output logic       INCREMENTA_GARRAFA,
    output logic       LED_ALARME,
    output logic [3:0] ESTADO
);

    localparam int LARGURA_TIMER =
        $clog2(maximo3(TIMEOUT_ENCHIMENTO, TEMPO_VEDACAO, TEMPO_CONTA) + 1);
    localparam logic [LARGURA_TIMER-1:0] c_PENULTIMO_VEDACAO =
        (TEMPO_VEDACAO >= 2) ? LARGURA_TIMER'(TEMPO_VEDACAO - 2) : '0;

    estado_t                  r_estado;
    estado_t                  w_prox;
    logic                     r_motor;
    logic                     r_valvula;
    logic                     r_atuador;
    logic                     r_decrementa;
    logic                     r_incrementa;
    logic                     r_led;
    logic [LARGURA_TIMER-1:0] w_contagem;
    logic [LARGURA_TIMER-1:0] w_limite;
    logic                     w_fim;
    logic                     w_limpa;
    logic                     w_ultimo_vedacao;

    always_comb begin
        w_limite = '0;
        case (r_estado)
            ENCHIMENTO: w_limite = LARGURA_TIMER'(TIMEOUT_ENCHIMENTO - 1);
            VEDACAO:    w_limite = LARGURA_TIMER'(TEMPO_VEDACAO - 1);
            CONTA:      w_limite = LARGURA_TIMER'(TEMPO_CONTA - 1);
            default:    w_limite = '0;
        endcase
    end

    temporizador_estado #(
        .LARGURA (LARGURA_TIMER)
    ) u_temporizador (
        .clk        (CLOCK),
        .rst        (RESET),
        .i_limpa    (w_limpa),
        .i_habilita (1'b1),
        .i_limite   (w_limite),
        .o_contagem (w_contagem),
        .o_fim      (w_fim)
    );

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            PARADO:
                if (LIGA && !LIMITE_DUZIAS && !ALARME_SEM_ROLHA) w_prox = TRANSPORTE;
            TRANSPORTE:
                if (SENSOR_POSICAO) w_prox = ENCHIMENTO;
                else if (!LIGA)     w_prox = PARADO;
            ENCHIMENTO:
                if (SENSOR_NIVEL) w_prox = AGUARDA_ROLHA;
                else if (w_fim)   w_prox = ERRO;
            AGUARDA_ROLHA:
                if (ROLHA_DISPONIVEL)      w_prox = VEDACAO;
                else if (ALARME_SEM_ROLHA) w_prox = ERRO;
            VEDACAO:
                if (w_fim) w_prox = LIBERA;
            LIBERA:
                if (!SENSOR_POSICAO) w_prox = CONTA;
            CONTA:
                if (w_fim) begin
                    if (LIMITE_DUZIAS) w_prox = LOTE_COMPLETO;
                    else if (LIGA)     w_prox = TRANSPORTE;
                    else               w_prox = PARADO;
                end
            LOTE_COMPLETO, ERRO:
                if (!LIGA) w_prox = PARADO;
            default:
                w_prox = PARADO;
        endcase
    end

    assign w_limpa = (w_prox != r_estado);

    // Outputs are registered, so the press pulse is decoded from the timer value the next cycle will hold.
    always_comb begin
        if (r_estado == VEDACAO) begin
            w_ultimo_vedacao = (w_prox == VEDACAO) && (w_contagem == c_PENULTIMO_VEDACAO);
        end else begin
            w_ultimo_vedacao = (w_prox == VEDACAO) && (TEMPO_VEDACAO == 1);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_estado     <= PARADO;
            r_motor      <= 1'b0;
            r_valvula    <= 1'b0;
            r_atuador    <= 1'b0;
            r_decrementa <= 1'b0;
            r_incrementa <= 1'b0;
            r_led        <= 1'b0;
        end else begin
            r_estado     <= w_prox;
            r_motor      <= (w_prox == TRANSPORTE) || (w_prox == LIBERA);
            r_valvula    <= (w_prox == ENCHIMENTO);
            r_atuador    <= (w_prox == VEDACAO);
            r_decrementa <= w_ultimo_vedacao;
            r_incrementa <= (w_prox == CONTA) && (r_estado != CONTA);
            r_led        <= (w_prox == ERRO);
        end
    end

    assign MOTOR_ESTEIRA      = r_motor;
    assign VALVULA_ENCHIMENTO = r_valvula;
    assign ATUADOR_VEDACAO    = r_atuador;
    assign DECREMENTA_ROLHA   = r_decrementa;
    assign INCREMENTA_GARRAFA = r_incrementa;
    assign LED_ALARME         = r_led;
    assign ESTADO             = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_controle_linha_vedacao.sv
`default_nettype none
// ============================================================================
// tb_controle_linha_vedacao
// Randomized and directed bench against a cycle-level reference model.
// Revision: 1.0
// ============================================================================
module tb_controle_linha_vedacao;
    import controle_linha_vedacao_pkg::*;

    localparam int TV = c_TEMPO_VEDACAO_PADRAO;
    localparam int TO = c_TIMEOUT_ENCHIMENTO_PADRAO;
    localparam int TC = c_TEMPO_CONTA_PADRAO;
    localparam int LOTE = 120;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       LIGA;
    logic       SENSOR_POSICAO;
    logic       SENSOR_NIVEL;
    logic       ROLHA_DISPONIVEL;
    logic       ALARME_SEM_ROLHA;
    logic       LIMITE_DUZIAS;
    logic       MOTOR_ESTEIRA;
    logic       VALVULA_ENCHIMENTO;
    logic       ATUADOR_VEDACAO;
    logic       DECREMENTA_ROLHA;
    logic       INCREMENTA_GARRAFA;
    logic       LED_ALARME;
    logic [3:0] ESTADO;

    controle_linha_vedacao #(
        .TEMPO_VEDACAO      (TV),
        .TIMEOUT_ENCHIMENTO (TO),
        .TEMPO_CONTA        (TC)
    ) dut (
        .CLOCK              (CLOCK),
        .RESET              (RESET),
        .LIGA               (LIGA),
        .SENSOR_POSICAO     (SENSOR_POSICAO),
        .SENSOR_NIVEL       (SENSOR_NIVEL),
        .ROLHA_DISPONIVEL   (ROLHA_DISPONIVEL),
        .ALARME_SEM_ROLHA   (ALARME_SEM_ROLHA),
        .LIMITE_DUZIAS      (LIMITE_DUZIAS),
        .MOTOR_ESTEIRA      (MOTOR_ESTEIRA),
        .VALVULA_ENCHIMENTO (VALVULA_ENCHIMENTO),
        .ATUADOR_VEDACAO    (ATUADOR_VEDACAO),
        .DECREMENTA_ROLHA   (DECREMENTA_ROLHA),
        .INCREMENTA_GARRAFA (INCREMENTA_GARRAFA),
        .LED_ALARME         (LED_ALARME),
        .ESTADO             (ESTADO)
    );

    always #5 CLOCK = ~CLOCK;

    int checks   = 0;
    int failures = 0;
    int m_st     = 0;   // model: station phase code
    int m_cnt    = 0;   // model: cycles spent in current phase
    int m_garrafas = 0; // bottles released since last RESET (stands in for sistema_garrafas)
    int dut_dec  = 0;
    int dut_inc  = 0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    function automatic logic [5:0] saidas_esperadas();
        return {(m_st == 1) || (m_st == 5), m_st == 2, m_st == 4,
                (m_st == 4) && (m_cnt == TV - 1), (m_st == 6) && (m_cnt == 0), m_st == 8};
    endfunction

    task automatic modelo_avanca();
        int nst;
        if (RESET) begin
            m_st = 0; m_cnt = 0; m_garrafas = 0;
            return;
        end
        nst = m_st;
        case (m_st)
            0: if (LIGA && !LIMITE_DUZIAS && !ALARME_SEM_ROLHA) nst = 1;
            1: if (SENSOR_POSICAO) nst = 2; else if (!LIGA) nst = 0;
            2: if (SENSOR_NIVEL) nst = 3; else if (m_cnt == TO - 1) nst = 8;
            3: if (ROLHA_DISPONIVEL) nst = 4; else if (ALARME_SEM_ROLHA) nst = 8;
            4: if (m_cnt == TV - 1) nst = 5;
            5: if (!SENSOR_POSICAO) nst = 6;
            6: if (m_cnt == TC - 1) nst = LIMITE_DUZIAS ? 7 : (LIGA ? 1 : 0);
            7, 8: if (!LIGA) nst = 0;
            default: nst = 0;
        endcase
        m_cnt = (nst != m_st) ? 0 : m_cnt + 1;
        m_st  = nst;
        if (m_st == 6 && m_cnt == 0) m_garrafas++;
    endtask

    task automatic passo();
        @(posedge CLOCK);
        modelo_avanca();
        #1;
        verifica("estado", 32'(ESTADO), 32'(m_st));
        verifica("saidas", 32'({MOTOR_ESTEIRA, VALVULA_ENCHIMENTO, ATUADOR_VEDACAO,
                                DECREMENTA_ROLHA, INCREMENTA_GARRAFA, LED_ALARME}),
                 32'(saidas_esperadas()));
        verifica("dec_inc_mesmo_ciclo", 32'(DECREMENTA_ROLHA & INCREMENTA_GARRAFA), 32'd0);
        if (DECREMENTA_ROLHA)   dut_dec++;
        if (INCREMENTA_GARRAFA) dut_inc++;
        LIMITE_DUZIAS = (m_garrafas >= LOTE);
    endtask

    task automatic ate_estado(input int alvo, input int limite, input string tag);
        for (int i = 0; i < limite && m_st != alvo; i++) passo();
        verifica(tag, 32'(ESTADO), 32'(alvo));
    endtask

    int dec0, inc0;

    initial begin
        RESET = 1'b1; LIGA = 1'b0; SENSOR_POSICAO = 1'b0; SENSOR_NIVEL = 1'b0;
        ROLHA_DISPONIVEL = 1'b1; ALARME_SEM_ROLHA = 1'b0; LIMITE_DUZIAS = 1'b0;
        repeat (3) passo();
        verifica("reset_estado", 32'(ESTADO), 32'd0);
        verifica("reset_motor", 32'(MOTOR_ESTEIRA), 32'd0);
        RESET = 1'b0;

        // Normal bottle
        LIGA = 1'b1;
        repeat (5) passo();
        SENSOR_POSICAO = 1'b1;
        ate_estado(2, 5, "normal_enchimento");
        repeat (10) passo();
        dec0 = dut_dec; inc0 = dut_inc;
        SENSOR_NIVEL = 1'b1;
        ate_estado(5, 40, "normal_libera");
        SENSOR_NIVEL = 1'b0;
        SENSOR_POSICAO = 1'b0;
        ate_estado(1, 10, "normal_volta_transporte");
        verifica("normal_dec", 32'(dut_dec - dec0), 32'd1);
        verifica("normal_inc", 32'(dut_inc - inc0), 32'd1);

        // Fill timeout
        SENSOR_POSICAO = 1'b1;
        ate_estado(2, 5, "timeout_enchimento");
        ate_estado(8, TO + 10, "timeout_erro");
        verifica("timeout_led", 32'(LED_ALARME), 32'd1);
        verifica("timeout_valvula", 32'(VALVULA_ENCHIMENTO), 32'd0);
        LIGA = 1'b0;
        ate_estado(0, 5, "timeout_parado");

        // Cork wait, then cork alarm
        LIGA = 1'b1; SENSOR_NIVEL = 1'b1; ROLHA_DISPONIVEL = 1'b0;
        ate_estado(3, 10, "rolha_aguarda");
        repeat (8) passo();
        verifica("rolha_segura", 32'(ESTADO), 32'd3);
        verifica("rolha_atuador", 32'(ATUADOR_VEDACAO), 32'd0);
        ROLHA_DISPONIVEL = 1'b1;
        passo();
        verifica("rolha_vedacao", 32'(ESTADO), 32'd4);
        ate_estado(5, 30, "rolha_libera");
        SENSOR_POSICAO = 1'b0;
        ate_estado(1, 10, "rolha_transporte");
        SENSOR_POSICAO = 1'b1; ROLHA_DISPONIVEL = 1'b0;
        ate_estado(3, 10, "alarme_aguarda");
        ALARME_SEM_ROLHA = 1'b1;
        passo();
        verifica("alarme_erro", 32'(ESTADO), 32'd8);
        LIGA = 1'b0; ALARME_SEM_ROLHA = 1'b0; ROLHA_DISPONIVEL = 1'b1;
        ate_estado(0, 5, "alarme_parado");

        // Stop mid-bottle
        LIGA = 1'b1;
        ate_estado(4, 20, "parada_vedacao");
        dec0 = dut_dec; inc0 = dut_inc;
        LIGA = 1'b0;
        ate_estado(5, 30, "parada_libera");
        SENSOR_POSICAO = 1'b0;
        ate_estado(0, 10, "parada_parado");
        verifica("parada_dec", 32'(dut_dec - dec0), 32'd1);
        verifica("parada_inc", 32'(dut_inc - inc0), 32'd1);

        // Reset during the 19th press cycle
        LIGA = 1'b1; SENSOR_POSICAO = 1'b1;
        ate_estado(4, 20, "reset_vedacao");
        for (int i = 0; i < 40 && !(m_st == 4 && m_cnt == TV - 2); i++) passo();
        dec0 = dut_dec;
        RESET = 1'b1;
        passo();
        RESET = 1'b0;
        verifica("reset_sem_dec", 32'(dut_dec - dec0), 32'd0);
        verifica("reset_meio_estado", 32'(ESTADO), 32'd0);
        verifica("reset_meio_atuador", 32'(ATUADOR_VEDACAO), 32'd0);

        // Randomized operation
        for (int i = 0; i < 3000; i++) begin
            LIGA             = ($urandom_range(0, 15) != 0);
            SENSOR_POSICAO   = ($urandom_range(0, 3) != 0);
            SENSOR_NIVEL     = ($urandom_range(0, 5) == 0);
            ROLHA_DISPONIVEL = ($urandom_range(0, 3) != 0);
            ALARME_SEM_ROLHA = ($urandom_range(0, 7) == 0);
            RESET            = ($urandom_range(0, 499) == 0);
            passo();
        end
        RESET = 1'b0;

        // Full lot of 120 bottles
        RESET = 1'b1;
        passo();
        RESET = 1'b0;
        inc0 = dut_inc;
        LIGA = 1'b1; ALARME_SEM_ROLHA = 1'b0; ROLHA_DISPONIVEL = 1'b1;
        for (int i = 0; i < 20000 && m_st != 7; i++) begin
            SENSOR_POSICAO = ($urandom_range(0, 1) != 0);
            SENSOR_NIVEL   = ($urandom_range(0, 3) == 0);
            passo();
        end
        verifica("lote_completo", 32'(ESTADO), 32'd7);
        verifica("lote_motor", 32'(MOTOR_ESTEIRA), 32'd0);
        verifica("lote_inc", 32'(dut_inc - inc0), 32'(LOTE));
        LIGA = 1'b0;
        ate_estado(0, 5, "lote_parado");
        LIGA = 1'b1;
        repeat (20) passo();
        verifica("lote_bloqueado", 32'(ESTADO), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
